zc_meas_mc: RTL and testbench

Synthesizable multi-channel zero-crossing frequency and peak-amplitude meter. It watches the per-sample audio words driven to the CODEC serializer and measures each channel's half-period spacing and signed peaks over a bounded window. The equalizer control logic or the LED driver uses it to check filter response in hardware. It generalises the bench-only two-channel, two-crossing measurement to N channels, averaged spans and timeout detection.

---
 rtl/eq_meas_pkg.sv | 24 ++
 rtl/zc_chan_meas.sv | 131 +++++++++++++
 rtl/zc_meas_mc.sv | 111 +++++++++++
 tb/tb_zc_meas_mc.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_meas_pkg.sv
// Shared types for the zero-crossing meter: top and per-channel FSM states
// plus the span accumulator width helper.
// No logic; imported by zc_meas_mc and zc_chan_meas.
package eq_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2
  } top_state_t;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    MEAS = 2'd1,
    FIN  = 2'd2,
    TOUT = 2'd3
  } chan_state_t;

  // Width of a sum of num_span saturated spans: never overflows.
  function automatic int sum_w(input int cnt_w, input int num_span);
    return cnt_w + $clog2(num_span);
  endfunction

endpackage

// File: rtl/zc_chan_meas.sv
// One channel of the zero-crossing meter: previous sample, span counter,
// span accumulator, signed peaks and the ARM/MEAS/FIN/TOUT state machine.
// Acts only on strobes from the top; results change only on a valid sample.
module zc_chan_meas
  import eq_meas_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 16,
  parameter int NUM_SPAN = 4,
  localparam int SUM_W   = sum_w(CNT_W, NUM_SPAN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     seed,
  input  logic                     smpl,
  input  logic                     tmo,
  input  logic signed [DATA_W-1:0] data,
  output logic        [SUM_W-1:0]  span_sum,
  output logic signed [DATA_W-1:0] peak_max,
  output logic signed [DATA_W-1:0] peak_min,
  output logic                     fin,
  output logic                     tout
);

  localparam int IDX_W = $clog2(NUM_SPAN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chan_state_t              state;
  chan_state_t              state_nxt;
  logic signed [DATA_W-1:0] prev;
  logic        [CNT_W-1:0]  cnt;
  logic        [CNT_W-1:0]  cnt_inc;
  logic        [IDX_W-1:0]  idx;
  logic                     active;
  logic                     xing;
  logic                     last_span;

  // Zero counts as positive, so a crossing is simply a sign-bit change.
  assign xing      = smpl && (data[DATA_W-1] != prev[DATA_W-1]);
  assign active    = (state == ARM) || (state == MEAS);
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign last_span = (idx == IDX_W'(NUM_SPAN - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a crossing that completes the last span beats a timeout on the same sample.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ARM;
    end else if (smpl) begin
      case (state)
        ARM: begin
          if (tmo) begin
            state_nxt = TOUT;
          end else if (xing) begin
            state_nxt = MEAS;
          end
        end
        MEAS: begin
          if (xing && last_span) begin
            state_nxt = FIN;
          end else if (tmo) begin
            state_nxt = TOUT;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    fin  = (state == FIN);
    tout = (state == TOUT);
  end

  // Datapath: seed, span counting with saturation, accumulation and peak tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= '0;
      cnt      <= '0;
      idx      <= '0;
      span_sum <= '0;
      peak_max <= '0;
      peak_min <= '0;
    end else if (clr) begin
      cnt      <= '0;
      idx      <= '0;
      span_sum <= '0;
    end else if (seed) begin
      prev     <= data;
      peak_max <= data;
      peak_min <= data;
      cnt      <= '0;
      idx      <= '0;
    end else if (smpl && active) begin
      prev <= data;
      if (data > peak_max) begin
        peak_max <= data;
      end
      if (data < peak_min) begin
        peak_min <= data;
      end
      if (state == MEAS) begin
        if (xing) begin
          span_sum <= span_sum + SUM_W'(cnt_inc);
          cnt      <= '0;
          idx      <= idx + IDX_W'(1);
        end else begin
          cnt <= cnt_inc;
        end
      end else if (xing) begin
        cnt <= '0;
      end
      // A timed-out channel reports no partial sum.
      if (state_nxt == TOUT) begin
        span_sum <= '0;
      end
    end
  end

endmodule

// File: rtl/zc_meas_mc.sv
// Multi-channel zero-crossing span and peak meter over a bounded sample window.
// done is registered one cycle after the sample that ends the last channel.
// No backpressure: samples arrive as strobes and are ignored outside SEED/RUN.
module zc_meas_mc
  import eq_meas_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 16,
  parameter int NUM_SPAN = 4,
  parameter int MAX_SMPL = 2048,
  localparam int SUM_W   = sum_w(CNT_W, NUM_SPAN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       smpl_vld,
  input  logic [NUM_CH*DATA_W-1:0]   smpl_data,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_CH*SUM_W-1:0]    span_sum,
  output logic [NUM_CH*DATA_W-1:0]   peak_max,
  output logic [NUM_CH*DATA_W-1:0]   peak_min,
  output logic [NUM_CH-1:0]          tout
);

  localparam int GC_W = $clog2(MAX_SMPL + 1);

  top_state_t        state;
  top_state_t        state_nxt;
  logic              start_acc;
  logic              seed_stb;
  logic              run_stb;
  logic              done_set;
  logic              tmo;
  logic              all_end;
  logic [GC_W-1:0]   gcnt;
  logic [NUM_CH-1:0] fin;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    zc_chan_meas #(
      .DATA_W   (DATA_W),
      .CNT_W    (CNT_W),
      .NUM_SPAN (NUM_SPAN)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_acc),
      .seed     (seed_stb),
      .smpl     (run_stb),
      .tmo      (tmo),
      .data     (smpl_data[c*DATA_W +: DATA_W]),
      .span_sum (span_sum[c*SUM_W +: SUM_W]),
      .peak_max (peak_max[c*DATA_W +: DATA_W]),
      .peak_min (peak_min[c*DATA_W +: DATA_W]),
      .fin      (fin[c]),
      .tout     (tout[c])
    );
  end

  assign all_end = &(fin | tout);
  assign tmo     = run_stb && (gcnt == GC_W'(MAX_SMPL - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: start only counts from IDLE; the first sample after it seeds.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = SEED;
      SEED:    if (smpl_vld) state_nxt = RUN;
      RUN:     if (all_end)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes to the channels and status; a start in IDLE swallows any coincident sample.
  always_comb begin
    start_acc = (state == IDLE) && start;
    seed_stb  = (state == SEED) && smpl_vld;
    run_stb   = (state == RUN) && smpl_vld;
    done_set  = (state == RUN) && all_end;
    busy      = (state != IDLE);
  end

  // done pulses in the cycle the state returns to IDLE, so busy falls with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= done_set;
    end
  end

  // Global window counter over valid samples in RUN.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      gcnt <= '0;
    end else if (run_stb && (gcnt != GC_W'(MAX_SMPL))) begin
      gcnt <= gcnt + GC_W'(1);
    end
  end

endmodule

// File: tb/tb_zc_meas_mc.sv
// Randomised bench for zc_meas_mc with a crossing-list reference model and
// a done-triggered scoreboard monitor.
module tb_zc_meas_mc;

  localparam int NUM_CH   = 2;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 5;
  localparam int NUM_SPAN = 4;
  localparam int MAX_SMPL = 300;
  localparam int SUM_W    = CNT_W + $clog2(NUM_SPAN);
  localparam int SAT      = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     smpl_vld;
  logic [NUM_CH*DATA_W-1:0] smpl_data;
  logic                     busy;
  logic                     done;
  logic [NUM_CH*SUM_W-1:0]  span_sum;
  logic [NUM_CH*DATA_W-1:0] peak_max;
  logic [NUM_CH*DATA_W-1:0] peak_min;
  logic [NUM_CH-1:0]        tout;

  int checks = 0;
  int errors = 0;
  int xs [NUM_CH][MAX_SMPL+1];
  int exp_q [$];

  zc_meas_mc #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .NUM_SPAN (NUM_SPAN),
    .MAX_SMPL (MAX_SMPL)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .smpl_vld  (smpl_vld),
    .smpl_data (smpl_data),
    .busy      (busy),
    .done      (done),
    .span_sum  (span_sum),
    .peak_max  (peak_max),
    .peak_min  (peak_min),
    .tout      (tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Fill one channel's waveform: 0 square +-amp, 1 square 0/-amp, 2 DC, 3 noise, 4 near-zero noise.
  task automatic set_wave(input int c, input int kind, input int hp, input int amp, input int ph);
    for (int i = 0; i <= MAX_SMPL; i++) begin
      case (kind)
        0:       xs[c][i] = (((i + ph) / hp) % 2 == 0) ? amp : -amp;
        1:       xs[c][i] = (((i + ph) / hp) % 2 == 0) ? 0 : -amp;
        2:       xs[c][i] = amp;
        3:       xs[c][i] = int'($urandom_range(0, 65535)) - 32768;
        default: xs[c][i] = int'($urandom_range(0, 4)) - 2;
      endcase
    end
  endtask

  // Reference: list the crossing indices, sum clipped gaps, take peaks up to the end sample.
  task automatic build_expect(output int last);
    last = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      int xc [$];
      int e;
      int s;
      int pmx;
      int pmn;
      int to;
      for (int i = 1; i <= MAX_SMPL; i++) begin
        if ((xs[c][i] < 0) != (xs[c][i-1] < 0)) xc.push_back(i);
      end
      s = 0;
      if (xc.size() > NUM_SPAN) begin
        to = 0;
        e  = xc[NUM_SPAN];
        for (int k = 1; k <= NUM_SPAN; k++) begin
          s += ((xc[k] - xc[k-1]) > SAT) ? SAT : (xc[k] - xc[k-1]);
        end
      end else begin
        to = 1;
        e  = MAX_SMPL;
      end
      pmx = xs[c][0];
      pmn = xs[c][0];
      for (int i = 1; i <= e; i++) begin
        if (xs[c][i] > pmx) pmx = xs[c][i];
        if (xs[c][i] < pmn) pmn = xs[c][i];
      end
      exp_q.push_back(s);
      exp_q.push_back(pmx);
      exp_q.push_back(pmn);
      exp_q.push_back(to);
      if (e > last) last = e;
    end
  endtask

  // Drive one measurement; samples are spaced by idle cycles so busy is seen falling before the next one.
  task automatic drive_meas(input bit coincide, input bit mid_start, input int stop_after, output int n);
    start     = 1'b1;
    smpl_vld  = coincide;
    smpl_data = {16'h8000, 16'h7fff};
    @(posedge clk); #1;
    start    = 1'b0;
    smpl_vld = 1'b0;
    chk("busy_rise", int'(busy), 1);
    n = 0;
    while (busy && n <= MAX_SMPL && n < stop_after) begin
      for (int c = 0; c < NUM_CH; c++) smpl_data[c*DATA_W +: DATA_W] = DATA_W'(xs[c][n]);
      smpl_vld = 1'b1;
      @(posedge clk); #1;
      smpl_vld = 1'b0;
      n++;
      if (mid_start && n == 20) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_one(input bit coincide, input bit mid_start);
    int last;
    int n;
    build_expect(last);
    drive_meas(coincide, mid_start && (last > 25), MAX_SMPL + 2, n);
    chk("run_len", n - 1, last);
    chk("busy_end", int'(busy), 0);
  endtask

  // Scoreboard monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("busy_at_done", int'(busy), 0);
      if (exp_q.size() < 4 * NUM_CH) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual done=1 required no done");
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          chk($sformatf("span_sum[%0d]", c), int'(span_sum[c*SUM_W +: SUM_W]), exp_q.pop_front());
          chk($sformatf("peak_max[%0d]", c), int'($signed(peak_max[c*DATA_W +: DATA_W])), exp_q.pop_front());
          chk($sformatf("peak_min[%0d]", c), int'($signed(peak_min[c*DATA_W +: DATA_W])), exp_q.pop_front());
          chk($sformatf("tout[%0d]", c), int'(tout[c]), exp_q.pop_front());
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_span_sum"}, int'(span_sum), 0);
    chk({tag, "_peak_max"}, int'(peak_max), 0);
    chk({tag, "_peak_min"}, int'(peak_min), 0);
    chk({tag, "_tout"}, int'(tout), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual still running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int kind;
    int hp;
    int amp;
    rst       = 1'b1;
    start     = 1'b0;
    smpl_vld  = 1'b0;
    smpl_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // ch0 half period 24, ch1 half period 12: done follows the later ch0 finish.
    set_wave(0, 0, 24, 3200, 0);
    set_wave(1, 0, 12, 3200, 0);
    run_one(1'b0, 1'b0);
    // ch1 stuck at DC +100 times out; ch0 still measured.
    set_wave(0, 0, 24, 3200, 5);
    set_wave(1, 2, 1, 100, 0);
    run_one(1'b0, 1'b0);
    // Half period 40 saturates every span.
    set_wave(0, 0, 40, 1234, 0);
    set_wave(1, 1, 3, 500, 1);
    run_one(1'b0, 1'b0);
    // start coincident with a sample, then a second start mid-run.
    set_wave(0, 0, 10, 20000, 3);
    set_wave(1, 3, 1, 0, 0);
    run_one(1'b1, 1'b0);
    set_wave(0, 0, 10, 700, 0);
    set_wave(1, 0, 9, 900, 2);
    run_one(1'b0, 1'b1);

    // Reset mid-run: everything clears and no done follows.
    set_wave(0, 0, 30, 4000, 0);
    set_wave(1, 0, 30, 4000, 0);
    drive_meas(1'b0, 1'b0, 12, n);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero("midrst");
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_still_idle", int'(busy), 0);

    // Fresh measurement after the reset.
    set_wave(0, 0, 24, 3200, 0);
    set_wave(1, 4, 1, 0, 0);
    run_one(1'b1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        kind = $urandom_range(0, 4);
        hp   = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 90) : $urandom_range(1, 45);
        amp  = $urandom_range(1, 32767);
        if (kind == 2 && $urandom_range(0, 1) == 1) amp = -amp;
        set_wave(c, kind, hp, amp, $urandom_range(0, hp - 1));
      end
      run_one(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("pending_done", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
